alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0001, initial operand LFSR value (nonzero).
REQ-002 SHALL have parameter SIG_SEED, default 32'hFFFF_FFFF, initial MISR signature value.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, run request sampled in IDLE or DONE.
REQ-006 SHALL have port goldenSig, input, 32, expected signature, captured when a run is accepted.
REQ-007 SHALL have ports ALUSrcA and ALUSrcB, output, 1 each, ALU operand-source selects.
REQ-008 SHALL have port ALUCtr, output, 3, ALU operation code.
REQ-009 SHALL have ports readData1, readData2 and ImExtend, output, 32 each, and shamt, output, 5: ALU operands.
REQ-010 SHALL have ports ALUData, input, 32, and zero, input, 1: ALU response, combinational from the driven operands.
REQ-011 SHALL have ports busy, done and pass, output, 1 each; signature, output, 32; vecCount, output, 6.

Function
REQ-012 SHALL implement states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 SHALL move IDLE->DRIVE or DONE->DRIVE on a clock edge with start=1, load lfsr=SEED, signature=SIG_SEED and vecCount=0, latch goldenSig, and clear done and pass.
REQ-014 SHALL ignore start in DRIVE and SAMPLE.
REQ-015 SHALL run 32 vectors, each vector DRIVE for one cycle then SAMPLE for one cycle; vector index i=vecCount[4:0].
REQ-016 SHALL drive per vector: ALUCtr=i[4:2], ALUSrcA=i[1], ALUSrcB=i[0], readData1=lfsr, readData2={lfsr[15:0],lfsr[31:16]}, ImExtend=~lfsr, shamt=lfsr[4:0].
REQ-017 SHALL hold the operand outputs constant across the DRIVE and SAMPLE cycles of one vector, and SHALL drive them to 0 in IDLE and DONE.
REQ-018 SHALL, on the edge ending SAMPLE, set signature <= {signature[30:0], fb(signature)} ^ ALUData ^ {31'b0, zero}.
REQ-019 SHALL, on the same edge, set lfsr <= {lfsr[30:0], fb(lfsr)} and vecCount <= vecCount+1.
REQ-020 SHALL define fb(x) as x[31]^x[21]^x[1]^x[0].
REQ-021 SHALL go SAMPLE->DRIVE when vecCount<31 and SAMPLE->DONE when vecCount==31; vecCount reads 32 in DONE.
REQ-022 SHALL assert busy in DRIVE and SAMPLE only, giving a latency from the accepting edge to done=1 of exactly 64 cycles.
REQ-023 SHALL, on entering DONE, register pass = (final signature == latched goldenSig), and hold done, pass and signature until the next accepted start or reset.

Reset
REQ-024 SHALL, while rst_n=0, immediately force the state to IDLE.
REQ-025 SHALL, while rst_n=0, force busy, done, pass, vecCount and all ALU-facing outputs to 0.
REQ-026 SHALL, while rst_n=0, force signature=SIG_SEED and lfsr=SEED.
REQ-027 SHALL abort a run cleanly when reset is asserted mid-run, with no partial state surviving after reset is released.

Configuration
REQ-028 SHALL, with macro ALU_BIST_FAILCNT_EN defined, add output failCount, 8 bits, which increments when entering DONE with pass=0, saturates at 255, is cleared only by reset, and is not cleared by start.
REQ-029 SHALL, without ALU_BIST_FAILCNT_EN, have no failCount port and no counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover reset: hold rst_n=0 -> busy=0, done=0, pass=0, vecCount=0, signature=32'hFFFFFFFF and all ALU outputs 0.
REQ-031 SHALL cover sequencing: pulse start with SEED=1 -> vector 0 gives readData1=32'h1 and ALUCtr=000 with sources 00; vector 1 gives readData1=32'h3 with sources 01; vector 2 gives readData1=32'h6; vector 4 gives ALUCtr=001.
REQ-032 SHALL cover latency: start accepted at edge N -> busy=1 from edge N through N+63, and done=1 with busy=0 at edge N+64.
REQ-033 SHALL cover pass/fail: connect the real ALU and set goldenSig to the software-model signature -> pass=1; rerun with goldenSig^1 -> pass=0, and failCount=1 when ALU_BIST_FAILCNT_EN is defined.
REQ-034 SHALL cover reset mid-run: assert rst_n=0 at vector 10 -> outputs take their reset values at once; release and start again -> signature identical to the uninterrupted run.
REQ-035 SHALL cover start while busy: hold start=1 throughout a run -> no restart, done at edge N+64, then a new run is accepted at edge N+65.

Source files
------------

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer.
//
// A 32-bit LFSR generates operands. Each of 32 vectors drives the ALU for one cycle (DRIVE),
// then samples the combinational ALU response for one cycle (SAMPLE) and folds it into a MISR
// signature. When the run completes, the signature is compared with a golden value latched at
// start.
//
// Parameters:
//   SEED      initial operand LFSR value (must be nonzero)
//   SIG_SEED  initial MISR signature value
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, accepted only in IDLE or DONE
//   goldenSig           expected signature, latched when a run is accepted
//   ALUSrcA, ALUSrcB    ALU operand-source selects
//   ALUCtr              ALU operation code
//   readData1/2         register operands
//   ImExtend            immediate operand
//   shamt               shift amount
//   ALUData, zero       combinational ALU response
//   busy, done, pass    run status
//   signature           current/final MISR value
//   vecCount            vectors completed (reads 32 in DONE)
//   failCount           failed-run counter, saturating (only when the optional feature is enabled)
//
// Optional feature: define ALU_BIST_FAILCNT_EN to add the failCount port and its counter.
module alu_bist #(
    parameter logic [31:0] SEED     = 32'h0000_0001,
    parameter logic [31:0] SIG_SEED = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] goldenSig,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ALUCtr,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] ImExtend,
    output logic [4:0]  shamt,
    input  logic [31:0] ALUData,
    input  logic        zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
`ifdef ALU_BIST_FAILCNT_EN
    output logic [5:0]  vecCount,
    output logic [7:0]  failCount
`else
    output logic [5:0]  vecCount
`endif
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] golden_q, golden_d;
    logic [5:0]  vec_q, vec_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] sig_upd;
    logic [31:0] lfsr_upd;
    logic        finishing;

    function automatic logic fb(input logic [31:0] x);
        return x[31] ^ x[21] ^ x[1] ^ x[0];
    endfunction

    assign sig_upd  = {sig_q[30:0], fb(sig_q)} ^ ALUData ^ {31'b0, zero};
    assign lfsr_upd = {lfsr_q[30:0], fb(lfsr_q)};

    // Last vector's SAMPLE edge: the run is about to enter DONE.
    assign finishing = (state_q == StSample) && (vec_q == 6'd31);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        sig_d    = sig_q;
        golden_d = golden_q;
        vec_d    = vec_q;
        done_d   = done_q;
        pass_d   = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StDrive;
                    lfsr_d   = SEED;
                    sig_d    = SIG_SEED;
                    golden_d = goldenSig;
                    vec_d    = 6'd0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            StDrive: begin
                state_d = StSample;
            end
            StSample: begin
                sig_d  = sig_upd;
                lfsr_d = lfsr_upd;
                vec_d  = vec_q + 6'd1;
                if (finishing) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (sig_upd == golden_q);
                end else begin
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lfsr_q   <= SEED;
            sig_q    <= SIG_SEED;
            golden_q <= 32'd0;
            vec_q    <= 6'd0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            sig_q    <= sig_d;
            golden_q <= golden_d;
            vec_q    <= vec_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // Operands derive from registered state only, so they stay stable across DRIVE and SAMPLE
    // and drop to zero the moment reset forces IDLE.
    always_comb begin
        busy      = (state_q == StDrive) || (state_q == StSample);
        ALUCtr    = 3'd0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        readData1 = 32'd0;
        readData2 = 32'd0;
        ImExtend  = 32'd0;
        shamt     = 5'd0;
        if (busy) begin
            ALUCtr    = vec_q[4:2];
            ALUSrcA   = vec_q[1];
            ALUSrcB   = vec_q[0];
            readData1 = lfsr_q;
            readData2 = {lfsr_q[15:0], lfsr_q[31:16]};
            ImExtend  = ~lfsr_q;
            shamt     = lfsr_q[4:0];
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vecCount  = vec_q;

`ifdef ALU_BIST_FAILCNT_EN
    logic [7:0] fail_q;

    // Survives start; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= 8'd0;
        end else if (finishing && (sig_upd != golden_q) && (fail_q != 8'hFF)) begin
            fail_q <= fail_q + 8'd1;
        end
    end

    assign failCount = fail_q;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist.
//
// A behavioural ALU closes the loop on the DUT's operand outputs; a software model of the
// LFSR/MISR walk supplies the golden signature. Directed checks cover reset values, vector
// sequencing, 64-cycle latency, pass/fail, mid-run reset and start held while busy.
// Define ALU_BIST_FAILCNT_EN to also exercise the failCount port.
module tb_alu_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] goldenSig;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [2:0]  ALUCtr;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] ImExtend;
    logic [4:0]  shamt;
    logic [31:0] ALUData;
    logic        zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [5:0]  vecCount;
`ifdef ALU_BIST_FAILCNT_EN
    logic [7:0]  failCount;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_sig;

    alu_bist #(
        .SEED     (32'h0000_0001),
        .SIG_SEED (32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .goldenSig (goldenSig),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUCtr    (ALUCtr),
        .readData1 (readData1),
        .readData2 (readData2),
        .ImExtend  (ImExtend),
        .shamt     (shamt),
        .ALUData   (ALUData),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
`ifdef ALU_BIST_FAILCNT_EN
        .vecCount  (vecCount),
        .failCount (failCount)
`else
        .vecCount  (vecCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] ctr, input logic sa, input logic sb,
                                           input logic [31:0] rd1, input logic [31:0] rd2,
                                           input logic [31:0] imm, input logic [4:0] sh);
        logic [31:0] a;
        logic [31:0] b;
        a = sa ? {27'd0, sh} : rd1;
        b = sb ? imm : rd2;
        case (ctr)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b << a[4:0];
            3'd6:    return b >> a[4:0];
            default: return {31'd0, $signed(a) < $signed(b)};
        endcase
    endfunction

    always_comb begin
        ALUData = alu_fn(ALUCtr, ALUSrcA, ALUSrcB, readData1, readData2, ImExtend, shamt);
        zero    = (ALUData == 32'd0);
    end

    function automatic logic fb_m(input logic [31:0] x);
        return x[31] ^ x[21] ^ x[1] ^ x[0];
    endfunction

    function automatic logic [31:0] sig_model();
        logic [31:0] l;
        logic [31:0] s;
        logic [31:0] r;
        logic [4:0]  i;
        l = 32'h0000_0001;
        s = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) begin
            i = k[4:0];
            r = alu_fn(i[4:2], i[1], i[0], l, {l[15:0], l[31:16]}, ~l, l[4:0]);
            s = {s[30:0], fb_m(s)} ^ r ^ {31'd0, r == 32'd0};
            l = {l[30:0], fb_m(l)};
        end
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs the remaining 63 edges after the accepting edge, checking busy throughout.
    task automatic finish_run(input string tag);
        int bad;
        bad = 0;
        for (int k = 1; k < 64; k++) begin
            tick(1);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check_eq({tag, "_busy_window"}, bad, 0);
        tick(1);
        check_eq({tag, "_done"}, {busy, done}, 2'b01);
    endtask

    initial begin
        int bad;
        model_sig = sig_model();
        rst_n     = 1'b0;
        start     = 1'b0;
        goldenSig = 32'd0;
        tick(2);

        // Reset values.
        check_eq("rst_status", {busy, done, pass}, 3'b000);
        check_eq("rst_vec", vecCount, 6'd0);
        check_eq("rst_sig", signature, 32'hFFFF_FFFF);
        check_eq("rst_ctl", {ALUSrcA, ALUSrcB, ALUCtr, shamt}, 10'd0);
        check_eq("rst_ops", readData1 | readData2 | ImExtend, 32'd0);
`ifdef ALU_BIST_FAILCNT_EN
        check_eq("rst_failcnt", failCount, 8'd0);
`endif
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_after_rst", {busy, done}, 2'b00);

        // Passing run with sequencing and latency checks; accepting edge is N.
        goldenSig = model_sig;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("v0_rd1", readData1, 32'h0000_0001);
        check_eq("v0_rd2", readData2, 32'h0001_0000);
        check_eq("v0_imm", ImExtend, 32'hFFFF_FFFE);
        check_eq("v0_ctl", {ALUCtr, ALUSrcA, ALUSrcB, shamt}, {3'd0, 2'b00, 5'd1});
        check_eq("v0_busy", {busy, vecCount}, {1'b1, 6'd0});
        bad = 0;
        for (int k = 1; k < 64; k++) begin
            tick(1);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == 1) check_eq("v0_hold", readData1, 32'h0000_0001);
            if (k == 2) check_eq("v1", {readData1, ALUSrcA, ALUSrcB}, {32'h3, 2'b01});
            if (k == 2) check_eq("v1_cnt", vecCount, 6'd1);
            if (k == 4) check_eq("v2", {readData1, ALUSrcA, ALUSrcB}, {32'h6, 2'b10});
            if (k == 8) check_eq("v4", {readData1, ALUCtr, ALUSrcA, ALUSrcB},
                                 {32'h1B, 3'b001, 2'b00});
        end
        check_eq("lat_busy_window", bad, 0);
        tick(1);
        check_eq("lat_done", {busy, done}, 2'b01);
        check_eq("pass_run_pass", pass, 1'b1);
        check_eq("pass_run_sig", signature, model_sig);
        check_eq("done_vec", vecCount, 6'd32);
        check_eq("done_ops", readData1 | ImExtend, 32'd0);
        tick(3);
        check_eq("done_hold", {done, pass, signature}, {2'b11, model_sig});
`ifdef ALU_BIST_FAILCNT_EN
        check_eq("failcnt_after_pass", failCount, 8'd0);
`endif

        // Failing run: golden off by one bit.
        goldenSig = model_sig ^ 32'd1;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("restart_clears", {busy, done, pass}, 3'b100);
        finish_run("fail_run");
        check_eq("fail_run_pass", pass, 1'b0);
        check_eq("fail_run_sig", signature, model_sig);
`ifdef ALU_BIST_FAILCNT_EN
        check_eq("failcnt_after_fail", failCount, 8'd1);
`endif

        // Reset mid-run at vector 10.
        goldenSig = model_sig;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        check_eq("mid_vec10", vecCount, 6'd10);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_status", {busy, done, pass, vecCount}, 9'd0);
        check_eq("mid_rst_sig", signature, 32'hFFFF_FFFF);
        check_eq("mid_rst_ops", readData1 | readData2 | ImExtend, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        finish_run("post_rst");
        check_eq("post_rst_sig", signature, model_sig);
        check_eq("post_rst_pass", pass, 1'b1);
`ifdef ALU_BIST_FAILCNT_EN
        check_eq("failcnt_rst", failCount, 8'd0);
`endif

        // Start held high throughout: no restart while busy.
        start = 1'b1;
        tick(1);
        bad = 0;
        for (int k = 1; k < 64; k++) begin
            tick(1);
            if (busy !== 1'b1 || vecCount !== 6'(k / 2)) bad++;
        end
        check_eq("held_no_restart", bad, 0);
        tick(1);
        check_eq("held_done", {busy, done, vecCount}, {2'b01, 6'd32});
        tick(1);
        check_eq("held_reaccept", {busy, done, vecCount}, {2'b10, 6'd0});
        start = 1'b0;
        finish_run("held_run2");
        check_eq("held_run2_pass", {pass, signature}, {1'b1, model_sig});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
